paddle_adc_reader: RTL and testbench

Reads the two paddle potentiometers through the board's 8-channel, 12-bit serial ADC (ADC128S022-style SPI) and produces the 8-bit `PADDLE_A_POSITION`/`PADDLE_B_POSITION` values that the game engine consumes. It runs a free-running, alternating two-channel conversion loop and scales each result to 8 bits. It clamps each result so that a doubled position plus the 75-line paddle stays on screen. It sits between the ADC pins and the game engine, on `SYSTEM_CLOCK`.

---
 rtl/paddle_adc_reader.sv | 244 ++++++++++++++++++++++++
 tb/tb_paddle_adc_reader.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_adc_reader.sv
// -----------------------------------------------------------------------------
// paddle_adc_reader
//
// Reads the two paddle potentiometers through an ADC128S022-style 8-channel,
// 12-bit SPI ADC. A free-running loop converts the two paddle channels in turn.
// Each result is scaled to 8 bits and clamped to MAX_POS, and the matching paddle
// position register is updated.
//
// Frame structure: after reset, CS is held high for 2*CLK_DIV cycles (IDLE).
// After that, back-to-back 16-slot frames run with CS held low. Each slot is
// SCLK low for CLK_DIV cycles, then SCLK high for CLK_DIV cycles. DIN changes
// on the cycle SCLK falls, and DOUT is captured on the cycle SCLK rises.
//
// Pipelining: the ADC answers in frame n for the address sent in frame n-1.
// The result of frame 0 is dropped. An odd frame's result belongs to paddle A,
// and an even frame's result (frame 2 and later) belongs to paddle B.
//
// Optional feature: define PADDLE_FILTER_EN to add a per-paddle 14-bit IIR
// accumulator (acc <- acc - acc/4 + sample; position = acc[13:6]).
//
// Parameters:
//   CLK_DIV  SYSTEM_CLOCK cycles per SCLK half-period (>= 2)
//   CHAN_A   ADC channel for paddle A
//   CHAN_B   ADC channel for paddle B
//   MAX_POS  upper clamp for both position outputs
//
// Ports:
//   SYSTEM_CLOCK       clock; all logic is on the rising edge
//   RESET              synchronous, active-high reset
//   ADC_CS_N           ADC chip select, active low
//   ADC_SCLK           ADC serial clock, idles high
//   ADC_DIN            channel address to the ADC
//   ADC_DOUT           conversion data from the ADC, MSB first
//   PADDLE_A_POSITION  clamped 8-bit position for paddle A
//   PADDLE_B_POSITION  clamped 8-bit position for paddle B
//   SAMPLE_VALID       one-cycle pulse when a position register updates
//   SAMPLE_CHANNEL     0 = paddle A updated, 1 = paddle B updated
// -----------------------------------------------------------------------------
module paddle_adc_reader #(
    parameter int unsigned CLK_DIV = 13,
    parameter logic [2:0]  CHAN_A  = 3'd0,
    parameter logic [2:0]  CHAN_B  = 3'd1,
    parameter logic [7:0]  MAX_POS = 8'd202
) (
    input  logic       SYSTEM_CLOCK,
    input  logic       RESET,
    output logic       ADC_CS_N,
    output logic       ADC_SCLK,
    output logic       ADC_DIN,
    input  logic       ADC_DOUT,
    output logic [7:0] PADDLE_A_POSITION,
    output logic [7:0] PADDLE_B_POSITION,
    output logic       SAMPLE_VALID,
    output logic       SAMPLE_CHANNEL
);

    // One counter serves both the IDLE hold (2*CLK_DIV) and the SCLK half-periods.
    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             phase_reg, phase_next;      // 0 = SCLK low half, 1 = high half
    logic [3:0]       slot_reg, slot_next;
    logic             parity_reg, parity_next;    // frame parity: 0 sends CHAN_A
    logic             first_frame_reg, first_frame_next;
    // Only the low 12 bits of each 16-bit frame are kept. The four leading bits
    // shift out of the top, so garbage in those bits never reaches the sample.
    logic [11:0]      shift_reg, shift_next;
    logic             cs_n_reg, cs_n_next;
    logic             sclk_reg, sclk_next;
    logic             din_reg, din_next;
    logic [7:0]       pos_a_reg, pos_a_next;
    logic [7:0]       pos_b_reg, pos_b_next;
    logic             valid_reg, valid_next;
    logic             chan_reg, chan_next;

    logic [2:0]       frame_addr;
    logic [3:0]       slot_inc;
    logic [7:0]       raw_pos;
    logic [7:0]       clamped_pos;

`ifdef PADDLE_FILTER_EN
    logic [13:0]      acc_a_reg, acc_a_next;
    logic [13:0]      acc_b_reg, acc_b_next;
    logic [13:0]      acc_sel;
    logic [13:0]      acc_upd;
`endif

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        phase_next       = phase_reg;
        slot_next        = slot_reg;
        parity_next      = parity_reg;
        first_frame_next = first_frame_reg;
        shift_next       = shift_reg;
        cs_n_next        = cs_n_reg;
        sclk_next        = sclk_reg;
        din_next         = din_reg;
        pos_a_next       = pos_a_reg;
        pos_b_next       = pos_b_reg;
        valid_next       = 1'b0;
        chan_next        = chan_reg;

        frame_addr = parity_reg ? CHAN_B : CHAN_A;
        slot_inc   = slot_reg + 4'd1;

`ifdef PADDLE_FILTER_EN
        acc_a_next = acc_a_reg;
        acc_b_next = acc_b_reg;
        // Odd frames carry paddle A's data, even frames carry paddle B's.
        acc_sel    = parity_reg ? acc_a_reg : acc_b_reg;
        acc_upd    = acc_sel - (acc_sel >> 2) + {2'b00, shift_reg};
        raw_pos    = acc_upd[13:6];
`else
        raw_pos    = shift_reg[11:4];
`endif
        clamped_pos = (raw_pos > MAX_POS) ? MAX_POS : raw_pos;

        case (state_reg)
            ST_IDLE: begin
                if (cnt_reg == IDLE_LAST) begin
                    state_next = ST_FRAME;
                    cnt_next   = '0;
                    phase_next = 1'b0;
                    slot_next  = 4'd0;
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                    din_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_FRAME: begin
                if (cnt_reg != HALF_LAST) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    cnt_next = '0;
                    if (!phase_reg) begin
                        // Rising SCLK: capture the bit the ADC launched CLK_DIV cycles ago.
                        phase_next = 1'b1;
                        sclk_next  = 1'b1;
                        shift_next = {shift_reg[10:0], ADC_DOUT};
                    end else begin
                        // Falling SCLK: move to the next slot. A wrap from 15 to 0
                        // starts the next frame at once, with CS kept low.
                        phase_next = 1'b0;
                        sclk_next  = 1'b0;
                        slot_next  = slot_inc;
                        case (slot_inc)
                            4'd2:    din_next = frame_addr[2];
                            4'd3:    din_next = frame_addr[1];
                            4'd4:    din_next = frame_addr[0];
                            default: din_next = 1'b0;
                        endcase
                        if (slot_reg == 4'd15) begin
                            parity_next      = ~parity_reg;
                            first_frame_next = 1'b0;
                            // Frame 0 returns data for no requested address; drop it.
                            if (!first_frame_reg) begin
                                valid_next = 1'b1;
                                chan_next  = ~parity_reg;
                                if (parity_reg) begin
                                    pos_a_next = clamped_pos;
`ifdef PADDLE_FILTER_EN
                                    acc_a_next = acc_upd;
`endif
                                end else begin
                                    pos_b_next = clamped_pos;
`ifdef PADDLE_FILTER_EN
                                    acc_b_next = acc_upd;
`endif
                                end
                            end
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYSTEM_CLOCK) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            phase_reg       <= 1'b0;
            slot_reg        <= 4'd0;
            parity_reg      <= 1'b0;
            first_frame_reg <= 1'b1;
            shift_reg       <= '0;
            cs_n_reg        <= 1'b1;
            sclk_reg        <= 1'b1;
            din_reg         <= 1'b0;
            pos_a_reg       <= 8'd0;
            pos_b_reg       <= 8'd0;
            valid_reg       <= 1'b0;
            chan_reg        <= 1'b0;
`ifdef PADDLE_FILTER_EN
            acc_a_reg       <= '0;
            acc_b_reg       <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            phase_reg       <= phase_next;
            slot_reg        <= slot_next;
            parity_reg      <= parity_next;
            first_frame_reg <= first_frame_next;
            shift_reg       <= shift_next;
            cs_n_reg        <= cs_n_next;
            sclk_reg        <= sclk_next;
            din_reg         <= din_next;
            pos_a_reg       <= pos_a_next;
            pos_b_reg       <= pos_b_next;
            valid_reg       <= valid_next;
            chan_reg        <= chan_next;
`ifdef PADDLE_FILTER_EN
            acc_a_reg       <= acc_a_next;
            acc_b_reg       <= acc_b_next;
`endif
        end
    end

    assign ADC_CS_N          = cs_n_reg;
    assign ADC_SCLK          = sclk_reg;
    assign ADC_DIN           = din_reg;
    assign PADDLE_A_POSITION = pos_a_reg;
    assign PADDLE_B_POSITION = pos_b_reg;
    assign SAMPLE_VALID      = valid_reg;
    assign SAMPLE_CHANNEL    = chan_reg;

endmodule

// File: tb/tb_paddle_adc_reader.sv
// -----------------------------------------------------------------------------
// tb_paddle_adc_reader
//
// Self-checking bench for paddle_adc_reader. A behavioural ADC128S022 model
// answers each frame with the conversion for the address captured in the
// previous frame. The four leading bits of each answer are random garbage.
//
// Expected positions come from the address/value pairs the model served. They
// are computed with plain arithmetic (sample/16, or the IIR formula when
// PADDLE_FILTER_EN is defined), then clamped to 202.
//
// Cycle numbering: cycle 1 is the first cycle after the last clock edge that
// sampled RESET high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_paddle_adc_reader;

    localparam int         CLK_DIV = 13;
    localparam logic [2:0] CHAN_A  = 3'd0;
    localparam logic [2:0] CHAN_B  = 3'd1;
    localparam int         MAX_POS = 202;
    localparam int         FIRST_A = 2 * CLK_DIV + 64 * CLK_DIV + 1;   // 859
    localparam int         FIRST_B = FIRST_A + 32 * CLK_DIV;           // 1275
    localparam int         WAIT_LIM = 70 * CLK_DIV;

    logic       SYSTEM_CLOCK = 1'b0;
    logic       RESET        = 1'b1;
    logic       ADC_CS_N;
    logic       ADC_SCLK;
    logic       ADC_DIN;
    logic       ADC_DOUT;
    logic [7:0] PADDLE_A_POSITION;
    logic [7:0] PADDLE_B_POSITION;
    logic       SAMPLE_VALID;
    logic       SAMPLE_CHANNEL;

    always #5 SYSTEM_CLOCK = ~SYSTEM_CLOCK;

    paddle_adc_reader #(
        .CLK_DIV (CLK_DIV),
        .CHAN_A  (CHAN_A),
        .CHAN_B  (CHAN_B),
        .MAX_POS (8'd202)
    ) dut (
        .SYSTEM_CLOCK      (SYSTEM_CLOCK),
        .RESET             (RESET),
        .ADC_CS_N          (ADC_CS_N),
        .ADC_SCLK          (ADC_SCLK),
        .ADC_DIN           (ADC_DIN),
        .ADC_DOUT          (ADC_DOUT),
        .PADDLE_A_POSITION (PADDLE_A_POSITION),
        .PADDLE_B_POSITION (PADDLE_B_POSITION),
        .SAMPLE_VALID      (SAMPLE_VALID),
        .SAMPLE_CHANNEL    (SAMPLE_CHANNEL)
    );

    // ---------------- ADC model (runs on the falling system clock) ----------
    logic [11:0] chan_val [8];
    logic [11:0] frame0_val;
    int          m_frame;
    int          m_slot;
    bit          m_started;
    logic        sclk_q;
    logic [15:0] cur_word;
    logic [2:0]  addr_acc;
    logic [2:0]  addr_log [256];
    logic [2:0]  ret_addr [256];
    logic [11:0] ret_val  [256];

    always @(negedge SYSTEM_CLOCK) begin
        if (ADC_CS_N !== 1'b0) begin
            m_started = 1'b0;
            m_frame   = 0;
            m_slot    = 0;
            sclk_q    = 1'b1;
            ADC_DOUT  = 1'b0;
        end else begin
            if (sclk_q === 1'b1 && ADC_SCLK === 1'b0) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_frame   = 0;
                    m_slot    = 0;
                end else if (m_slot == 15) begin
                    m_slot  = 0;
                    m_frame = m_frame + 1;
                end else begin
                    m_slot = m_slot + 1;
                end
                if (m_slot == 0) begin
                    if (m_frame == 0) begin
                        cur_word = {4'($urandom), frame0_val};
                    end else begin
                        ret_addr[m_frame & 255] = addr_log[(m_frame - 1) & 255];
                        ret_val[m_frame & 255]  = chan_val[ret_addr[m_frame & 255]];
                        cur_word = {4'($urandom), ret_val[m_frame & 255]};
                    end
                    addr_acc = 3'b000;
                end
                ADC_DOUT = cur_word[15 - m_slot];
            end else if (sclk_q === 1'b0 && ADC_SCLK === 1'b1) begin
                if (m_slot >= 2 && m_slot <= 4) addr_acc = {addr_acc[1:0], ADC_DIN};
                if (m_slot == 4) addr_log[m_frame & 255] = addr_acc;
            end
            sclk_q = ADC_SCLK;
        end
    end

    // ---------------- checker state --------------------------------------
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    int   cs_bad;
    int   falls;
    logic prev_sclk;
    int   rd;
    int   exp_a, exp_b, acc_a, acc_b;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        int          a_nf;
        int          b_nf;
        int          a_f;
        int          b_f;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge SYSTEM_CLOCK);
        #3;
        cyc++;
        if (cyc <= 2 * CLK_DIV) begin
            if (ADC_CS_N !== 1'b1) cs_bad++;
        end else if (ADC_CS_N !== 1'b0) begin
            cs_bad++;
        end
        if (prev_sclk === 1'b1 && ADC_SCLK === 1'b0 &&
            cyc >= 2 * CLK_DIV + 1 && cyc <= 2 * CLK_DIV + 32 * CLK_DIV) falls++;
        prev_sclk = ADC_SCLK;
    endtask

    task automatic hold_reset();
        @(posedge SYSTEM_CLOCK);
        #3;
        RESET = 1'b1;
        repeat (2) @(posedge SYSTEM_CLOCK);
        #3;
        RESET     = 1'b0;
        cyc       = 1;
        cs_bad    = 0;
        falls     = 0;
        prev_sclk = 1'b1;
        rd        = 1;
        exp_a     = 0;
        exp_b     = 0;
        acc_a     = 0;
        acc_b     = 0;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < WAIT_LIM; i++) begin
            tick();
            if (SAMPLE_VALID === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_chan(input logic ch, output bit got);
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
            bit g;
            wait_valid(g);
            if (!g) break;
            if (SAMPLE_CHANNEL === ch) got = 1'b1;
        end
    endtask

    // Position after one update with sample v, from the paddle's rules.
    task automatic model_update(inout int acc, input int v, output int pos);
        int raw;
        acc = acc - acc / 4 + v;
`ifdef PADDLE_FILTER_EN
        raw = acc / 64;
`else
        raw = v / 16;
`endif
        pos = (raw > MAX_POS) ? MAX_POS : raw;
    endtask

    task automatic sb_check();
        int idx;
        int ch;
        int v;
        if (m_frame < rd) begin
            check("sb_frame_recorded", m_frame, rd);
        end else begin
            idx = rd & 255;
            ch  = (ret_addr[idx] == CHAN_A) ? 0 : 1;
            v   = int'(ret_val[idx]);
            if (ch == 0) model_update(acc_a, v, exp_a);
            else         model_update(acc_b, v, exp_b);
            check($sformatf("sb%0d_chan", rd), SAMPLE_CHANNEL, ch);
            check($sformatf("sb%0d_pos_a", rd), PADDLE_A_POSITION, exp_a);
            check($sformatf("sb%0d_pos_b", rd), PADDLE_B_POSITION, exp_b);
        end
        rd++;
    endtask

    function automatic logic [11:0] pick();
        case ($urandom_range(0, 4))
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'hC90 + 12'($urandom_range(0, 47));
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        bit got;
        int want_a, want_b;
        int prev, mono_bad, first_step;

        for (int c = 0; c < 8; c++) chan_val[c] = 12'h000;
        frame0_val = 12'hFFF;

        tbl[0] = '{a: 12'hFFF, b: 12'h000, a_nf: 202, b_nf: 0,   a_f: 63, b_f: 0};
        tbl[1] = '{a: 12'h5A3, b: 12'hCA0, a_nf: 90,  b_nf: 202, a_f: 22, b_f: 50};
        tbl[2] = '{a: 12'hCA0, b: 12'hCBF, a_nf: 202, b_nf: 202, a_f: 50, b_f: 50};
        tbl[3] = '{a: 12'h800, b: 12'h7FF, a_nf: 128, b_nf: 127, a_f: 32, b_f: 31};
        tbl[4] = '{a: 12'h00F, b: 12'hC9F, a_nf: 0,   b_nf: 201, a_f: 0,  b_f: 50};
        tbl[5] = '{a: 12'h010, b: 12'h001, a_nf: 1,   b_nf: 0,   a_f: 0,  b_f: 0};

        // ---- reset state
        repeat (2) @(posedge SYSTEM_CLOCK);
        #3;
        check("rst_cs_n", ADC_CS_N, 1);
        check("rst_sclk", ADC_SCLK, 1);
        check("rst_din", ADC_DIN, 0);
        check("rst_pos_a", PADDLE_A_POSITION, 0);
        check("rst_pos_b", PADDLE_B_POSITION, 0);
        check("rst_valid", SAMPLE_VALID, 0);
        check("rst_chan", SAMPLE_CHANNEL, 0);

        // ---- table: first A and B updates after reset
        for (int r = 0; r < 6; r++) begin
            chan_val[CHAN_A] = tbl[r].a;
            chan_val[CHAN_B] = tbl[r].b;
`ifdef PADDLE_FILTER_EN
            want_a = tbl[r].a_f;
            want_b = tbl[r].b_f;
`else
            want_a = tbl[r].a_nf;
            want_b = tbl[r].b_nf;
`endif
            hold_reset();
            wait_valid(got);
            check($sformatf("t%0d_a_seen", r), got, 1);
            check($sformatf("t%0d_a_cycle", r), cyc, FIRST_A);
            check($sformatf("t%0d_a_chan", r), SAMPLE_CHANNEL, 0);
            check($sformatf("t%0d_a_pos", r), PADDLE_A_POSITION, want_a);
            check($sformatf("t%0d_b_not_yet", r), PADDLE_B_POSITION, 0);
            if (r == 0) begin
                tick();
                check("valid_one_cycle", SAMPLE_VALID, 0);
            end
            wait_valid(got);
            check($sformatf("t%0d_b_seen", r), got, 1);
            check($sformatf("t%0d_b_cycle", r), cyc, FIRST_B);
            check($sformatf("t%0d_b_chan", r), SAMPLE_CHANNEL, 1);
            check($sformatf("t%0d_b_pos", r), PADDLE_B_POSITION, want_b);
            check($sformatf("t%0d_a_hold", r), PADDLE_A_POSITION, want_a);
            if (r == 0) begin
                check("cs_timing_bad_cycles", cs_bad, 0);
                check("sclk_falls_first_frame", falls, 16);
                check("addr_frame0", addr_log[0], CHAN_A);
                check("addr_frame1", addr_log[1], CHAN_B);
                check("addr_frame2", addr_log[2], CHAN_A);
            end
        end

        // ---- step response on paddle A
        chan_val[CHAN_A] = 12'h000;
        chan_val[CHAN_B] = 12'h400;
        hold_reset();
        wait_chan(1'b0, got);
        check("step_pre_seen", got, 1);
        check("step_pre_a", PADDLE_A_POSITION, 0);
        chan_val[CHAN_A] = 12'h800;
        prev       = 0;
        mono_bad   = 0;
        first_step = 0;
        for (int u = 1; u <= 40; u++) begin
            wait_chan(1'b0, got);
            if (!got) begin
                check("step_update_seen", got, 1);
                break;
            end
            if (u == 1) first_step = int'(PADDLE_A_POSITION);
            if (int'(PADDLE_A_POSITION) < prev) mono_bad++;
            prev = int'(PADDLE_A_POSITION);
`ifndef PADDLE_FILTER_EN
            if (u == 3) break;
`endif
        end
`ifdef PADDLE_FILTER_EN
        check("step_first_update", first_step, 32);
`else
        check("step_first_update", first_step, 128);
`endif
        check("step_monotonic_bad", mono_bad, 0);
        check("step_settled", PADDLE_A_POSITION, 128);

        // ---- reset in slot 7 of frame 3
        chan_val[CHAN_A] = 12'h800;
        chan_val[CHAN_B] = 12'h7FF;
        hold_reset();
        for (int i = 0; i < 4 * 32 * CLK_DIV; i++) begin
            tick();
            if (m_started && m_frame == 3 && m_slot == 7) break;
        end
        check("midrst_reached_slot", m_frame * 16 + m_slot, 3 * 16 + 7);
`ifdef PADDLE_FILTER_EN
        check("midrst_pre_a", PADDLE_A_POSITION, 32);
        check("midrst_pre_b", PADDLE_B_POSITION, 31);
`else
        check("midrst_pre_a", PADDLE_A_POSITION, 128);
        check("midrst_pre_b", PADDLE_B_POSITION, 127);
`endif
        check("midrst_pre_cs", ADC_CS_N, 0);
        RESET = 1'b1;
        @(posedge SYSTEM_CLOCK);
        #3;
        check("midrst_cs_n", ADC_CS_N, 1);
        check("midrst_sclk", ADC_SCLK, 1);
        check("midrst_pos_a", PADDLE_A_POSITION, 0);
        check("midrst_pos_b", PADDLE_B_POSITION, 0);
        hold_reset();
        wait_valid(got);
        check("midrst_post_seen", got, 1);
        check("midrst_post_cycle", cyc, FIRST_A);
        check("midrst_post_chan", SAMPLE_CHANNEL, 0);
        check("midrst_post_addr0", addr_log[0], CHAN_A);

        // ---- randomized run against the scoreboard
        chan_val[CHAN_A] = pick();
        chan_val[CHAN_B] = pick();
        hold_reset();
        for (int n = 0; n < 40; n++) begin
            wait_valid(got);
            if (!got) begin
                check("rand_valid_seen", got, 1);
                break;
            end
            sb_check();
            chan_val[CHAN_A] = pick();
            chan_val[CHAN_B] = pick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
